// File: rtl/neander_x_muldiv_seq.sv
// -----------------------------------------------------------------------------
// neander_x_muldiv_seq
//   Iterative MUL / DIV / MOD sequencer for the NEANDER-X datapath.
//   MUL uses shift-add over a 2*WIDTH product register.
//   DIV and MOD use restoring division.
//   Result, high and carry encodings match ALU ops 1001/1010/1011.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start_i   request, accepted only in IDLE or DONE
//   abort_i   synchronous cancel; also blocks a start in the same cycle
//   op_i      00 MUL, 01 DIV, 10 MOD, 11 reserved
//   a_i/b_i   multiplicand/dividend, multiplier/divisor
//   busy_o    high while iterating
//   done_o    one-cycle completion pulse
//   result_o  MUL low | DIV quotient | MOD remainder
//   high_o    MUL high | DIV remainder | MOD quotient
//   carry_o   MUL: high!=0; DIV/MOD: divide-by-zero
//
// Configuration macro: NEANDER_X_MULDIV_EARLY_TERM_EN
//   When defined, MUL finishes once the remaining multiplier bits are all zero.
// -----------------------------------------------------------------------------
module neander_x_muldiv_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic [WIDTH-1:0] high_o,
   output logic             carry_o
);

   // S_SHORT is the single non-busy cycle for divide-by-zero and the reserved op.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_SHORT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] OP_MUL = 2'b00;
   localparam logic [1:0] OP_DIV = 2'b01;
   localparam logic [1:0] OP_MOD = 2'b10;

   state_t             r_state;
   logic [3:0]         r_cnt;
   logic [1:0]         r_op;
   logic [WIDTH-1:0]   r_opa;
   logic [WIDTH-1:0]   r_opb;
   logic [2*WIDTH-1:0] r_prod;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_q;
`ifdef NEANDER_X_MULDIV_EARLY_TERM_EN
   logic [WIDTH-1:0]   r_mrem;
`endif

   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_acc_next;
   logic [2*WIDTH-1:0] w_prod_next;
   logic [2*WIDTH-1:0] w_prod_final;
   logic               w_mul_last;
   logic [WIDTH:0]     w_shift;
   logic               w_qbit;
   logic [WIDTH-1:0]   w_diff;
   logic [WIDTH-1:0]   w_rem_next;
   logic [WIDTH-1:0]   w_q_next;
   logic               w_short;

   // One shift-add step and one restoring-divide step, computed from the current registers.
   always_comb begin
      w_sum       = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_opa};
      w_acc_next  = r_prod[0] ? w_sum : {1'b0, r_prod[2*WIDTH-1:WIDTH]};
      w_prod_next = {w_acc_next, r_prod[WIDTH-1:1]};
`ifdef NEANDER_X_MULDIV_EARLY_TERM_EN
      // The remaining shifts only move zeros in, so apply them all at once.
      w_mul_last   = ((r_mrem >> 1) == {WIDTH{1'b0}});
      w_prod_final = w_prod_next >> r_cnt;
`else
      w_mul_last   = (r_cnt == 4'd0);
      w_prod_final = w_prod_next;
`endif
      w_shift = {r_rem, r_q[WIDTH-1]};
      w_qbit  = (w_shift >= {1'b0, r_opb});
      // The remainder after a successful trial is below the divisor, so the low WIDTH bits are exact.
      w_diff     = w_shift[WIDTH-1:0] - r_opb;
      w_rem_next = w_qbit ? w_diff : w_shift[WIDTH-1:0];
      w_q_next   = {r_q[WIDTH-2:0], w_qbit};
      w_short    = (op_i == 2'b11) || ((op_i != OP_MUL) && (b_i == {WIDTH{1'b0}}));
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= 4'd0;
         r_op     <= 2'b00;
         r_opa    <= {WIDTH{1'b0}};
         r_opb    <= {WIDTH{1'b0}};
         r_prod   <= {(2*WIDTH){1'b0}};
         r_rem    <= {WIDTH{1'b0}};
         r_q      <= {WIDTH{1'b0}};
`ifdef NEANDER_X_MULDIV_EARLY_TERM_EN
         r_mrem   <= {WIDTH{1'b0}};
`endif
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         result_o <= {WIDTH{1'b0}};
         high_o   <= {WIDTH{1'b0}};
         carry_o  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               done_o <= 1'b0;
               if (start_i && !abort_i) begin
                  r_op   <= op_i;
                  r_opa  <= a_i;
                  r_opb  <= b_i;
                  r_cnt  <= 4'(WIDTH - 1);
                  r_prod <= {{WIDTH{1'b0}}, b_i};
                  r_rem  <= {WIDTH{1'b0}};
                  r_q    <= a_i;
`ifdef NEANDER_X_MULDIV_EARLY_TERM_EN
                  r_mrem <= b_i;
`endif
                  if (w_short) begin
                     r_state <= S_SHORT;
                     busy_o  <= 1'b0;
                  end else begin
                     r_state <= S_RUN;
                     busy_o  <= 1'b1;
                  end
               end else begin
                  r_state <= S_IDLE;
                  busy_o  <= 1'b0;
               end
            end
            S_RUN: begin
               if (abort_i) begin
                  r_state <= S_IDLE;
                  busy_o  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
                  case (r_op)
                     OP_MUL: begin
                        r_prod <= w_prod_next;
`ifdef NEANDER_X_MULDIV_EARLY_TERM_EN
                        r_mrem <= r_mrem >> 1;
`endif
                        if (w_mul_last) begin
                           r_state  <= S_DONE;
                           busy_o   <= 1'b0;
                           done_o   <= 1'b1;
                           result_o <= w_prod_final[WIDTH-1:0];
                           high_o   <= w_prod_final[2*WIDTH-1:WIDTH];
                           carry_o  <= (w_prod_final[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
                        end else begin
                           r_state <= S_RUN;
                        end
                     end
                     OP_DIV, OP_MOD: begin
                        r_rem <= w_rem_next;
                        r_q   <= w_q_next;
                        if (r_cnt == 4'd0) begin
                           r_state  <= S_DONE;
                           busy_o   <= 1'b0;
                           done_o   <= 1'b1;
                           result_o <= (r_op == OP_DIV) ? w_q_next : w_rem_next;
                           high_o   <= (r_op == OP_DIV) ? w_rem_next : w_q_next;
                           carry_o  <= 1'b0;
                        end else begin
                           r_state <= S_RUN;
                        end
                     end
                     default: begin
                        // The reserved op never enters RUN; recover to IDLE if it does.
                        r_state <= S_IDLE;
                        busy_o  <= 1'b0;
                     end
                  endcase
               end
            end
            S_SHORT: begin
               if (abort_i) begin
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_DONE;
                  done_o  <= 1'b1;
                  case (r_op)
                     OP_DIV: begin
                        result_o <= {WIDTH{1'b1}};
                        high_o   <= r_q;
                        carry_o  <= 1'b1;
                     end
                     OP_MOD: begin
                        result_o <= r_q;
                        high_o   <= {WIDTH{1'b1}};
                        carry_o  <= 1'b1;
                     end
                     default: begin
                        result_o <= {WIDTH{1'b0}};
                        high_o   <= {WIDTH{1'b0}};
                        carry_o  <= 1'b0;
                     end
                  endcase
               end
            end
            default: begin
               r_state <= S_IDLE;
               busy_o  <= 1'b0;
               done_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_neander_x_muldiv_seq.sv
module tb_neander_x_muldiv_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_i;
   logic       abort_i;
   logic [1:0] op_i;
   logic [7:0] a_i;
   logic [7:0] b_i;
   logic       busy_o;
   logic       done_o;
   logic [7:0] result_o;
   logic [7:0] high_o;
   logic       carry_o;

   int total = 0;
   int bad   = 0;

`ifdef NEANDER_X_MULDIV_EARLY_TERM_EN
   localparam int LM03 = 2;
   localparam int LM10 = 5;
   localparam bit EARLY = 1'b1;
`else
   localparam int LM03 = 8;
   localparam int LM10 = 8;
   localparam bit EARLY = 1'b0;
`endif

   neander_x_muldiv_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
      .op_i(op_i), .a_i(a_i), .b_i(b_i), .busy_o(busy_o), .done_o(done_o),
      .result_o(result_o), .high_o(high_o), .carry_o(carry_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain arithmetic on the operation definitions.
   function automatic void model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] res, output logic [7:0] hi,
                                 output logic c, output int lat, output bit run);
      int p;
      int msb;
      p = 0; msb = -1; run = 1'b1; lat = 8;
      case (op)
         2'b00: begin
            p = int'(a) * int'(b);
            res = 8'(p % 256); hi = 8'(p / 256); c = (hi != 8'h00);
            if (EARLY) begin
               for (int i = 0; i < 8; i++) if (b[i]) msb = i;
               lat = (msb + 1 < 1) ? 1 : msb + 1;
            end
         end
         2'b01, 2'b10: begin
            if (b == 8'h00) begin
               res = (op == 2'b01) ? 8'hFF : a;
               hi  = (op == 2'b01) ? a : 8'hFF;
               c = 1'b1; lat = 1; run = 1'b0;
            end else begin
               res = (op == 2'b01) ? a / b : a % b;
               hi  = (op == 2'b01) ? a % b : a / b;
               c = 1'b0;
            end
         end
         default: begin
            res = 8'h00; hi = 8'h00; c = 1'b0; lat = 1; run = 1'b0;
         end
      endcase
   endfunction

   // Issue one op, scramble inputs afterwards, and report the latency seen and busy behaviour.
   task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input bit exp_run, input int exp_lat, output int lat, output bit busy_ok);
      @(negedge clk);
      start_i = 1'b1; op_i = op; a_i = a; b_i = b;
      @(posedge clk); #1;
      start_i = 1'b0; op_i = 2'($urandom); a_i = 8'($urandom); b_i = 8'($urandom);
      lat = 0; busy_ok = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         if (busy_o !== (exp_run && (n - 1 < exp_lat))) busy_ok = 1'b0;
         @(posedge clk); #1;
         if (done_o === 1'b1) begin
            lat = n;
            break;
         end
      end
      if (busy_o !== 1'b0) busy_ok = 1'b0;
   endtask

   typedef struct {
      logic [1:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [7:0] hi;
      logic       c;
      int         lat;
      bit         run;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int lat;
      bit bok;
      logic [7:0] mres, mhi;
      logic mc;
      int mlat;
      bit mrun;
      bit seen;
      int n;

      vecs[0] = '{2'b00, 8'hC8, 8'h03, 8'h58, 8'h02, 1'b1, LM03, 1'b1};
      vecs[1] = '{2'b01, 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 8, 1'b1};
      vecs[2] = '{2'b10, 8'hFF, 8'h10, 8'h0F, 8'h0F, 1'b0, 8, 1'b1};
      vecs[3] = '{2'b01, 8'h2A, 8'h00, 8'hFF, 8'h2A, 1'b1, 1, 1'b0};
      vecs[4] = '{2'b10, 8'h2A, 8'h00, 8'h2A, 8'hFF, 1'b1, 1, 1'b0};
      vecs[5] = '{2'b00, 8'h10, 8'h10, 8'h00, 8'h01, 1'b1, LM10, 1'b1};
      vecs[6] = '{2'b11, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0, 1, 1'b0};
      vecs[7] = '{2'b00, 8'h55, 8'h03, 8'hFF, 8'h00, 1'b0, LM03, 1'b1};

      rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; op_i = 2'b00; a_i = 8'h00; b_i = 8'h00;
      repeat (3) @(posedge clk);
      #1 chk("reset_outputs", {busy_o, done_o, result_o, high_o, carry_o}, 19'h0);
      @(negedge clk) rst_n = 1'b1;

      // Directed table.
      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].run, vecs[i].lat, lat, bok);
         chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
         chk($sformatf("vec%0d_result", i), result_o, vecs[i].res);
         chk($sformatf("vec%0d_high", i), high_o, vecs[i].hi);
         chk($sformatf("vec%0d_carry", i), carry_o, vecs[i].c);
         chk($sformatf("vec%0d_busy", i), bok, 1'b1);
      end

      // Random ops against the reference model.
      for (int i = 0; i < 30; i++) begin
         logic [1:0] rop;
         logic [7:0] ra, rb;
         rop = 2'($urandom);
         ra  = 8'($urandom);
         rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         model(rop, ra, rb, mres, mhi, mc, mlat, mrun);
         run_op(rop, ra, rb, mrun, mlat, lat, bok);
         chk($sformatf("rnd%0d_lat", i), lat, mlat);
         chk($sformatf("rnd%0d_result", i), result_o, mres);
         chk($sformatf("rnd%0d_high", i), high_o, mhi);
         chk($sformatf("rnd%0d_carry", i), carry_o, mc);
         chk($sformatf("rnd%0d_busy", i), bok, 1'b1);
      end

      // Start pulse during RUN is ignored; then back-to-back start during DONE.
      @(negedge clk);
      start_i = 1'b1; op_i = 2'b00; a_i = 8'h10; b_i = 8'h10;
      @(posedge clk); #1 start_i = 1'b0;
      seen = 1'b0;
      for (int k = 1; k <= LM10; k++) begin
         @(negedge clk);
         start_i = (k == 3);
         if (k == 3) begin op_i = 2'b01; a_i = 8'h05; b_i = 8'h01; end
         @(posedge clk); #1 start_i = 1'b0;
         if (k < LM10 && done_o === 1'b1) seen = 1'b1;
      end
      chk("ign_start_no_early_done", seen, 1'b0);
      chk("ign_start_done", done_o, 1'b1);
      chk("ign_start_vals", {result_o, high_o, carry_o}, {8'h00, 8'h01, 1'b1});
      @(negedge clk);
      start_i = 1'b1; op_i = 2'b01; a_i = 8'd100; b_i = 8'd7;
      @(posedge clk); #1 start_i = 1'b0;
      chk("b2b_busy", busy_o, 1'b1);
      chk("b2b_done_pulse_len", done_o, 1'b0);
      n = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (done_o === 1'b1) begin n = k; break; end
      end
      chk("b2b_lat", n, 8);
      chk("b2b_vals", {result_o, high_o, carry_o}, {8'h0E, 8'h02, 1'b0});

      // Abort sampled at edge 4 of a DIV.
      @(negedge clk);
      start_i = 1'b1; op_i = 2'b01; a_i = 8'h80; b_i = 8'h03;
      @(posedge clk); #1 start_i = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk) abort_i = (k == 4);
         @(posedge clk); #1;
      end
      abort_i = 1'b0;
      chk("abort_busy", busy_o, 1'b0);
      seen = 1'b0;
      repeat (12) begin @(posedge clk); #1 if (done_o === 1'b1) seen = 1'b1; end
      chk("abort_no_done", seen, 1'b0);
      chk("abort_keeps_outputs", {result_o, high_o, carry_o}, {8'h0E, 8'h02, 1'b0});

      // Abort together with start in IDLE.
      @(negedge clk);
      start_i = 1'b1; abort_i = 1'b1; op_i = 2'b00; a_i = 8'h11; b_i = 8'h22;
      @(posedge clk); #1 begin start_i = 1'b0; abort_i = 1'b0; end
      chk("abort_start_busy", busy_o, 1'b0);
      seen = 1'b0;
      repeat (10) begin @(posedge clk); #1 if (done_o === 1'b1) seen = 1'b1; end
      chk("abort_start_no_done", seen, 1'b0);

      // Asynchronous reset mid-RUN.
      @(negedge clk);
      start_i = 1'b1; op_i = 2'b00; a_i = 8'hC8; b_i = 8'hFF;
      @(posedge clk); #1 start_i = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs", {busy_o, done_o, result_o, high_o, carry_o}, 19'h0);
      @(negedge clk) rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin @(posedge clk); #1 if (done_o === 1'b1) seen = 1'b1; end
      chk("async_reset_no_done", seen, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
